// File: rtl/ram_access_arbiter.sv
// rtl/ram_access_arbiter.sv - three-requester round-robin arbiter in front of a single-port command RAM
module ram_access_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              req_valid,
  input  logic [2:0]              req_we,
  input  logic [3*ADDR_WIDTH-1:0] req_addr,
  input  logic [3*DATA_WIDTH-1:0] req_wdata,
  output logic [2:0]              req_ready,
  output logic [2:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [DATA_WIDTH-1:0]   ram_opcode,
  output logic [DATA_WIDTH-1:0]   ram_operand,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  output logic                    ram_read_enable,
  output logic                    ram_write_enable,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  output logic                    busy
);

  // RAM command words understood by the memory block
  localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(16'h9100);
  localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(16'h4200);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Round-robin pointer: index of the requester searched first, 0..2 only
  logic [1:0]            rr_ptr;

  // Command latched from the winner at the IDLE sample
  logic [1:0]            cmd_idx;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  // Arbitration results for the current cycle
  logic                  win_found;
  logic [1:0]            win_idx;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [1:0]            idx0, idx1, idx2;
  logic [3:0]            valid_pad;

  // Wrap-around successor in the 0 -> 1 -> 2 -> 0 ring; an illegal 3 recovers to 0
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // Search order starting at rr_ptr; the first set valid bit in that order wins
  always_comb begin
    valid_pad = {1'b0, req_valid};
    idx0      = rr_ptr;
    idx1      = next_idx(idx0);
    idx2      = next_idx(idx1);
    win_found = 1'b1;
    win_idx   = 2'd0;
    if (valid_pad[idx0]) begin
      win_idx = idx0;
    end else if (valid_pad[idx1]) begin
      win_idx = idx1;
    end else if (valid_pad[idx2]) begin
      win_idx = idx2;
    end else begin
      win_found = 1'b0;
    end
  end

  // Select the winner's command fields out of the packed request buses
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    case (win_idx)
      2'd0: begin
        win_we    = req_we[0];
        win_addr  = req_addr[ADDR_WIDTH-1:0];
        win_wdata = req_wdata[DATA_WIDTH-1:0];
      end
      2'd1: begin
        win_we    = req_we[1];
        win_addr  = req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH];
        win_wdata = req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      2'd2: begin
        win_we    = req_we[2];
        win_addr  = req_addr[3*ADDR_WIDTH-1:2*ADDR_WIDTH];
        win_wdata = req_wdata[3*DATA_WIDTH-1:2*DATA_WIDTH];
      end
      default: begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: every transaction is exactly IDLE -> ACCESS -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = win_found ? ACCESS : IDLE;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: the RAM bus is driven only in ACCESS, all zero otherwise
  always_comb begin
    ram_opcode       = '0;
    ram_operand      = '0;
    ram_write_data   = '0;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    busy             = (state != IDLE);
    if (state == ACCESS) begin
      ram_operand = DATA_WIDTH'(cmd_addr);
      if (cmd_we) begin
        ram_opcode       = OP_WRITE;
        ram_write_data   = cmd_wdata;
        ram_write_enable = 1'b1;
      end else begin
        ram_opcode      = OP_READ;
        ram_read_enable = 1'b1;
      end
    end
  end

  // Latch the winner's command at the IDLE sample; requests seen later are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_idx   <= 2'd0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (state == IDLE && win_found) begin
      cmd_idx   <= win_idx;
      cmd_we    <= win_we;
      cmd_addr  <= win_addr;
      cmd_wdata <= win_wdata;
    end
  end

  // Advance the round-robin pointer past the winner once its response has gone out
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= 2'd0;
    end else if (state == RESP) begin
      rr_ptr <= next_idx(cmd_idx);
    end
  end

  // Registered handshakes: ready during ACCESS, response and read data during RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready <= 3'b000;
      rsp_valid <= 3'b000;
      rsp_rdata <= '0;
    end else begin
      req_ready <= (state == IDLE && win_found) ? onehot(win_idx) : 3'b000;
      rsp_valid <= (state == ACCESS) ? onehot(cmd_idx) : 3'b000;
      if (state == ACCESS) begin
        rsp_rdata <= cmd_we ? '0 : ram_read_data;
      end else begin
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb/tb_ram_access_arbiter.sv - randomized self-checking bench for ram_access_arbiter
module tb_ram_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid, req_we;
  logic [23:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata, ram_opcode, ram_operand, ram_write_data, ram_read_data;
  logic        ram_read_enable, ram_write_enable, busy;

  always #5 clk = ~clk;

  ram_access_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_opcode(ram_opcode), .ram_operand(ram_operand), .ram_write_data(ram_write_data),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .ram_read_data(ram_read_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // RAM behind the arbiter: combinational read, write on the rising edge
  logic [15:0] mem [256];
  assign ram_read_data = ram_read_enable ? mem[ram_operand[7:0]] : 16'h0000;
  always @(posedge clk) if (ram_write_enable) mem[ram_operand[7:0]] <= ram_write_data;

  // Reference model: one transaction in flight, phase 0 idle, 1 access, 2 response
  logic [15:0] shadow [256];
  int          m_phase = 0;
  int          m_rr = 0;
  int          m_w = 0;
  logic        m_we = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [15:0] m_wdata = 16'h0, m_rdata = 16'h0, m_old = 16'h0;
  int          grants[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (m_phase == 1 && m_we) shadow[m_addr] = m_old;
      m_phase = 0;
      m_rr = 0;
    end else if (m_phase == 2) begin
      m_rr = (m_w + 1) % 3;
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (req_valid != 3'b000) begin
      m_w = -1;
      for (int k = 0; k < 3; k++)
        if (m_w < 0 && req_valid[(m_rr + k) % 3]) m_w = (m_rr + k) % 3;
      m_we    = req_we[m_w];
      m_addr  = req_addr[8*m_w +: 8];
      m_wdata = req_wdata[16*m_w +: 16];
      m_old   = shadow[m_addr];
      m_rdata = m_we ? 16'h0000 : shadow[m_addr];
      if (m_we) shadow[m_addr] = m_wdata;
      grants.push_back(m_w);
      m_phase = 1;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  int re_cycles = 0;
  always @(negedge clk) begin
    logic [2:0]  e_ready, e_rsp;
    logic [15:0] e_op, e_opd, e_wd;
    logic        e_re, e_we, e_busy;
    e_ready = 3'b000; e_rsp = 3'b000; e_op = 16'h0; e_opd = 16'h0; e_wd = 16'h0;
    e_re = 1'b0; e_we = 1'b0; e_busy = (m_phase != 0);
    if (m_phase == 1) begin
      e_ready[m_w] = 1'b1;
      e_op  = m_we ? 16'h9100 : 16'h4200;
      e_opd = {8'h00, m_addr};
      e_wd  = m_we ? m_wdata : 16'h0;
      e_re  = !m_we;
      e_we  = m_we;
    end
    if (m_phase == 2) e_rsp[m_w] = 1'b1;
    if (ram_read_enable) re_cycles++;
    check("req_ready", req_ready, e_ready);
    check("rsp_valid", rsp_valid, e_rsp);
    check("ram_opcode", ram_opcode, e_op);
    check("ram_operand", ram_operand, e_opd);
    check("ram_write_data", ram_write_data, e_wd);
    check("ram_enables", {ram_read_enable, ram_write_enable}, {e_re, e_we});
    check("busy", busy, e_busy);
    if (m_phase == 2) check("rsp_rdata", rsp_rdata, m_rdata);
    if (!reset) check("rsp_rdata_reset", rsp_rdata, 16'h0);
  end

  logic [15:0] snap_op, snap_opd, snap_wd;
  logic [1:0]  snap_en;
  logic [2:0]  snap_ready;

  // Single transaction from an idle arbiter; records the ACCESS-cycle bus
  task automatic do_txn(input int i, input logic we, input logic [7:0] a, input logic [15:0] d,
                        output logic [15:0] rd);
    int n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[8*i +: 8] = a; req_wdata[16*i +: 16] = d;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!req_ready[i] && n < 20);
    check("ready_latency", n, 1);
    snap_op = ram_opcode; snap_opd = ram_operand; snap_wd = ram_write_data;
    snap_en = {ram_read_enable, ram_write_enable}; snap_ready = req_ready;
    req_valid[i] = 1'b0;
    @(posedge clk); #1;
    check("rsp_after_ready", rsp_valid, 3'b001 << i);
    rd = rsp_rdata;
  endtask

  // All three requesters contend; each drops on ready and re-raises on response
  task automatic run_all(input int rounds);
    int got[3];
    int n, done;
    for (int i = 0; i < 3; i++) begin
      got[i] = 0; req_valid[i] = 1'b1; req_we[i] = 1'b0; req_addr[8*i +: 8] = 8'h40 + 8'(i);
    end
    n = 0; done = 0;
    while (done < 3*rounds && n < 200) begin
      @(posedge clk); #1; n++;
      for (int i = 0; i < 3; i++) begin
        if (req_ready[i]) req_valid[i] = 1'b0;
        if (rsp_valid[i]) begin
          got[i]++; done++;
          if (got[i] < rounds) req_valid[i] = 1'b1;
        end
      end
    end
    check("run_all_done", done, 3*rounds);
    req_valid = 3'b000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int r0;
    int pending[3];
    reset = 1'b0; req_valid = 3'b000; req_we = 3'b000; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      shadow[i] = mem[i];
    end
    mem[255] = 16'h1234; shadow[255] = 16'h1234;
    repeat (3) @(posedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_handshakes", {req_ready, rsp_valid}, 6'b0);
    reset = 1'b1;

    // Write then read back through requester 1
    do_txn(1, 1'b1, 8'h10, 16'hBEEF, rd);
    check("wr_opcode", snap_op, 16'h9100);
    check("wr_operand", snap_opd, 16'h0010);
    check("wr_data", snap_wd, 16'hBEEF);
    check("wr_enables", snap_en, 2'b01);
    check("wr_ready", snap_ready, 3'b010);
    check("wr_rdata_zero", rd, 16'h0000);
    do_txn(1, 1'b0, 8'h10, 16'h0000, rd);
    check("rd_back_beef", rd, 16'hBEEF);

    // Top-of-memory read through requester 2
    r0 = re_cycles;
    do_txn(2, 1'b0, 8'hFF, 16'h0000, rd);
    @(posedge clk); #1;
    check("rd_ff_opcode", snap_op, 16'h4200);
    check("rd_ff_operand", snap_opd, 16'h00FF);
    check("rd_ff_data", rd, 16'h1234);
    check("rd_ff_re_cycles", re_cycles - r0, 1);

    // Reset while idle
    @(posedge clk); #2 reset = 1'b0; #1;
    check("idle_reset_busy", busy, 0);
    repeat (2) @(posedge clk); #1 reset = 1'b1;

    // Reset during ACCESS of a write: transaction abandoned, RAM untouched
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[7:0] = 8'h20; req_wdata[15:0] = 16'hDEAD;
    @(posedge clk); #1;
    check("abort_ready", req_ready, 3'b001);
    req_valid = 3'b000;
    #1 reset = 1'b0; #1;
    check("abort_outputs", {req_ready, rsp_valid, ram_read_enable, ram_write_enable, busy}, 9'b0);
    check("abort_opcode", ram_opcode, 16'h0000);
    repeat (2) begin @(posedge clk); #1; check("abort_no_rsp", rsp_valid, 3'b000); end
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; check("abort_no_rsp_after", rsp_valid, 3'b000); end
    do_txn(0, 1'b0, 8'h20, 16'h0000, rd);
    check("abort_ram_untouched", rd, 16'h7A7A);

    // Full contention from reset: strict rotation
    @(posedge clk); #1 reset = 1'b0;
    req_valid = 3'b111; req_we = 3'b000;
    @(posedge clk); #1 reset = 1'b1;
    grants.delete();
    run_all(2);
    check("rot_count", grants.size(), 6);
    for (int i = 0; i < 6 && i < grants.size(); i++) check("rot_order", grants[i], i % 3);

    // Skip over an idle requester, then pointer returns to 0
    grants.delete();
    do_txn(0, 1'b0, 8'h01, 16'h0, rd);
    do_txn(2, 1'b0, 8'h02, 16'h0, rd);
    check("skip_grant", grants.size() == 2 ? grants[1] : -1, 2);
    grants.delete();
    run_all(1);
    check("skip_then_first", grants.size() > 0 ? grants[0] : -1, 0);

    // Requests toggled during ACCESS/RESP are ignored
    grants.delete();
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[7:0] = 8'h33; req_wdata[15:0] = 16'h5555;
    @(posedge clk); #1;
    check("noise_ready", req_ready, 3'b001);
    req_valid = 3'b110; req_we = 3'b111; req_addr = 24'($urandom); req_wdata = 48'($urandom);
    @(negedge clk);
    req_valid = 3'b011; req_addr[7:0] = 8'hC3;
    #1;
    check("noise_operand", ram_operand, 16'h0033);
    check("noise_wdata", ram_write_data, 16'h5555);
    @(posedge clk); #1;
    check("noise_rsp", rsp_valid, 3'b001);
    req_valid = 3'b000;
    repeat (3) @(posedge clk); #1;
    check("noise_no_extra_grant", grants.size(), 1);

    // Randomized traffic under the requester contract
    grants.delete();
    for (int i = 0; i < 3; i++) pending[i] = 0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (pending[i] != 0) begin
          if (req_ready[i]) begin req_valid[i] = 1'b0; pending[i] = 0; end
        end else if (c < 650 && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_we[i] = 1'($urandom);
          req_addr[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
          req_wdata[16*i +: 16] = 16'($urandom);
          pending[i] = 1;
        end
      end
    end
    check("random_drained", pending[0] + pending[1] + pending[2], 0);
    check("random_traffic", grants.size() > 50, 1);
    req_valid = 3'b000;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
